// File: rtl/dvi_pkg.sv
// Shared constants and types for the TMDS receiver.
package dvi_pkg;

    localparam int unsigned WORD_W     = 10;
    localparam int unsigned COLOR_W    = 8;
    localparam int unsigned CTRL_W     = 2;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned NUM_LANES  = 3;

    // Lane positions inside the 3-bit TMDS data bus {red, green, blue}
    localparam int unsigned LANE_BLUE  = 0;
    localparam int unsigned LANE_GREEN = 1;
    localparam int unsigned LANE_RED   = 2;

    // Lock thresholds
    localparam int unsigned EDGE_LOCK   = 4;
    localparam int unsigned EDGE_CNT_W  = 3;
    localparam int unsigned TOKEN_LOCK  = 8;
    localparam int unsigned TOKEN_CNT_W = 4;

    // Control tokens, indexed by {C1, C0}
    localparam logic [WORD_W-1:0] TOKEN_C00 = 10'h354;
    localparam logic [WORD_W-1:0] TOKEN_C01 = 10'h0AB;
    localparam logic [WORD_W-1:0] TOKEN_C10 = 10'h154;
    localparam logic [WORD_W-1:0] TOKEN_C11 = 10'h2AB;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/tmds_decode.sv
// Combinational TMDS 10b symbol decoder for one lane.
module tmds_decode
    import dvi_pkg::*;
(
    input  logic [WORD_W-1:0]  q,
    output logic               is_ctrl_c,
    output logic [CTRL_W-1:0]  ctrl_c,
    output logic [COLOR_W-1:0] data_c
);

    logic [COLOR_W-1:0] d_c;

    // Token match first, then undo the optional inversion and XOR/XNOR chain
    always_comb begin
        is_ctrl_c = 1'b1;
        ctrl_c    = 2'b00;
        d_c       = q[9] ? ~q[COLOR_W-1:0] : q[COLOR_W-1:0];
        data_c    = '0;

        case (q)
            TOKEN_C00: ctrl_c = 2'b00;
            TOKEN_C01: ctrl_c = 2'b01;
            TOKEN_C10: ctrl_c = 2'b10;
            TOKEN_C11: ctrl_c = 2'b11;
            default:   is_ctrl_c = 1'b0;
        endcase

        data_c[0] = d_c[0];
        for (int i = 1; i < int'(COLOR_W); i++) begin
            data_c[i] = q[8] ? (d_c[i] ^ d_c[i-1]) : ~(d_c[i] ^ d_c[i-1]);
        end
    end

endmodule

// File: rtl/dvi_to_rgb.sv
// TMDS receiver: word alignment from the clock lane, per-lane decode, lock tracking
// and registered RGB/sync/DE output, all on the bit-rate clock.
module dvi_to_rgb
    import dvi_pkg::*;
#(
    parameter int kDebug      = 0,
    parameter int kEmulateDDC = 0,
    parameter int kClkRange   = 2
) (
    input  logic        RefClk,
    input  logic        aRst,
    input  logic        TMDS_Clk_p,
    input  logic        TMDS_Clk_n,
    input  logic [2:0]  TMDS_Data_p,
    input  logic [2:0]  TMDS_Data_n,
    output logic [23:0] vid_pData,
    output logic        vid_pVDE,
    output logic        vid_pHSync,
    output logic        vid_pVSync,
    output logic        vid_pStb,
    output logic        PixelClk,
    output logic        aPixelClkLckd,
    output logic        pLocked,
    input  logic        SDA_I,
    input  logic        SCL_I,
    output logic        SDA_O,
    output logic        SCL_O,
    output logic        SDA_T,
    output logic        SCL_T
);

    logic                   clk_lane_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]      lane_sr [NUM_LANES];
    logic                   word_done;
    logic [EDGE_CNT_W-1:0]  edge_cnt;
    logic [TOKEN_CNT_W-1:0] tok_cnt;
    pixel_t                 pix_q;

    logic                   clk_rise_c;
    logic                   misplaced_c;
    logic                   good_edge_c;
    logic [BIT_CNT_W-1:0]   bit_idx_c;
    logic                   all_data_c;
    logic                   blue_ctrl_c;

    logic                   dec_is_ctrl_c [NUM_LANES];
    logic [CTRL_W-1:0]      dec_ctrl_c    [NUM_LANES];
    logic [COLOR_W-1:0]     dec_data_c    [NUM_LANES];

    logic                   unused_inputs;

    // DDC lines tied off: released, drivers low
    assign SDA_O = 1'b0;
    assign SCL_O = 1'b0;
    assign SDA_T = 1'b1;
    assign SCL_T = 1'b1;

    // Negative legs, DDC inputs and configuration have no functional effect
    assign unused_inputs = ^{TMDS_Clk_n, TMDS_Data_n, SDA_I, SCL_I,
                             (kDebug != 0), (kEmulateDDC != 0), (kClkRange != 0)};

    // A clock-lane rising edge marks bit 0; anywhere else it is a misplaced edge
    assign clk_rise_c  = TMDS_Clk_p & ~clk_lane_q;
    assign misplaced_c = clk_rise_c && (bit_cnt != '0);
    assign good_edge_c = clk_rise_c && (bit_cnt == '0);
    assign bit_idx_c   = clk_rise_c ? '0 : bit_cnt;

    // One decoder per lane, fed by the completed word held in the shift register
    for (genvar l = 0; l < int'(NUM_LANES); l++) begin : g_lane
        tmds_decode u_dec (
            .q         (lane_sr[l]),
            .is_ctrl_c (dec_is_ctrl_c[l]),
            .ctrl_c    (dec_ctrl_c[l]),
            .data_c    (dec_data_c[l])
        );
    end

    assign all_data_c  = !dec_is_ctrl_c[LANE_RED] && !dec_is_ctrl_c[LANE_GREEN]
                         && !dec_is_ctrl_c[LANE_BLUE];
    assign blue_ctrl_c = dec_is_ctrl_c[LANE_BLUE];

    // Bit counter, LSB-first lane shift registers and divided pixel clock
    always_ff @(posedge RefClk or posedge aRst) begin
        if (aRst) begin
            clk_lane_q <= 1'b0;
            bit_cnt    <= '0;
            word_done  <= 1'b0;
            PixelClk   <= 1'b0;
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                lane_sr[l] <= '0;
            end
        end else begin
            clk_lane_q <= TMDS_Clk_p;
            bit_cnt    <= (bit_idx_c == BIT_CNT_W'(WORD_W - 1)) ? '0
                                                                : bit_idx_c + BIT_CNT_W'(1);
            word_done  <= (bit_idx_c == BIT_CNT_W'(WORD_W - 1));
            PixelClk   <= (bit_idx_c < BIT_CNT_W'(WORD_W / 2));
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                lane_sr[l] <= {TMDS_Data_p[l], lane_sr[l][WORD_W-1:1]};
            end
        end
    end

    // Clock-lane lock: consecutive well-placed edges, dropped by any misplaced edge
    always_ff @(posedge RefClk or posedge aRst) begin
        if (aRst) begin
            edge_cnt      <= '0;
            aPixelClkLckd <= 1'b0;
        end else if (misplaced_c) begin
            edge_cnt      <= '0;
            aPixelClkLckd <= 1'b0;
        end else if (good_edge_c && (edge_cnt != EDGE_CNT_W'(EDGE_LOCK))) begin
            edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
            if (edge_cnt == EDGE_CNT_W'(EDGE_LOCK - 1)) begin
                aPixelClkLckd <= 1'b1;
            end
        end
    end

    // Link lock: consecutive blue control tokens while the clock lane is locked
    always_ff @(posedge RefClk or posedge aRst) begin
        if (aRst) begin
            tok_cnt <= '0;
            pLocked <= 1'b0;
        end else if (!aPixelClkLckd || misplaced_c) begin
            tok_cnt <= '0;
            pLocked <= 1'b0;
        end else if (word_done) begin
            if (blue_ctrl_c) begin
                if (tok_cnt != TOKEN_CNT_W'(TOKEN_LOCK)) begin
                    tok_cnt <= tok_cnt + TOKEN_CNT_W'(1);
                end
                if (tok_cnt == TOKEN_CNT_W'(TOKEN_LOCK - 1)) begin
                    pLocked <= 1'b1;
                end
            end else begin
                tok_cnt <= '0;
            end
        end
    end

    // Registered video outputs, updated once per completed word
    always_ff @(posedge RefClk or posedge aRst) begin
        if (aRst) begin
            pix_q      <= '0;
            vid_pVDE   <= 1'b0;
            vid_pHSync <= 1'b0;
            vid_pVSync <= 1'b0;
            vid_pStb   <= 1'b0;
        end else begin
            vid_pStb <= word_done;
            if (word_done) begin
                if (pLocked && blue_ctrl_c) begin
                    vid_pHSync <= dec_ctrl_c[LANE_BLUE][0];
                    vid_pVSync <= dec_ctrl_c[LANE_BLUE][1];
                end
                if (pLocked && all_data_c) begin
                    vid_pVDE <= 1'b1;
                    pix_q.r  <= dec_data_c[LANE_RED];
                    pix_q.g  <= dec_data_c[LANE_GREEN];
                    pix_q.b  <= dec_data_c[LANE_BLUE];
                end else begin
                    vid_pVDE <= 1'b0;
                    pix_q    <= '0;
                end
            end
        end
    end

    assign vid_pData = pix_q;

endmodule

// File: tb/tb_dvi_to_rgb.sv
// Directed bench for dvi_to_rgb: serialises 10-bit TMDS words LSB first with a
// matching clock lane and checks lock, sync, DE and decoded pixel values.
module tb_dvi_to_rgb;

    logic        RefClk = 1'b0;
    logic        aRst;
    logic        TMDS_Clk_p;
    logic        TMDS_Clk_n;
    logic [2:0]  TMDS_Data_p;
    logic [2:0]  TMDS_Data_n;
    logic [23:0] vid_pData;
    logic        vid_pVDE;
    logic        vid_pHSync;
    logic        vid_pVSync;
    logic        vid_pStb;
    logic        PixelClk;
    logic        aPixelClkLckd;
    logic        pLocked;
    logic        SDA_I, SCL_I;
    logic        SDA_O, SCL_O, SDA_T, SCL_T;

    localparam logic [9:0] T354 = 10'h354;
    localparam logic [9:0] T0AB = 10'h0AB;
    localparam logic [9:0] T154 = 10'h154;
    localparam logic [9:0] T2AB = 10'h2AB;
    localparam logic [9:0] D1FF = 10'h1FF;   // decodes to 0x01
    localparam logic [9:0] D2F0 = 10'h2F0;   // decodes to 0xEF
    localparam logic [9:0] D155 = 10'h155;   // decodes to 0xFF

    int checks = 0;
    int errors = 0;

    // Snapshots taken by the word driver and the strobe monitor
    logic        s_lck0, s_plk0, s_pclk0, s_pclk5;
    logic [23:0] snap_data = '0;
    logic        snap_vde = 1'b0;
    int          stb_seen = 0;
    int          wide_stb = 0;
    logic        prev_stb = 1'b0;
    int          stb_before;

    always #5 RefClk = ~RefClk;

    dvi_to_rgb dut (
        .RefClk        (RefClk),
        .aRst          (aRst),
        .TMDS_Clk_p    (TMDS_Clk_p),
        .TMDS_Clk_n    (TMDS_Clk_n),
        .TMDS_Data_p   (TMDS_Data_p),
        .TMDS_Data_n   (TMDS_Data_n),
        .vid_pData     (vid_pData),
        .vid_pVDE      (vid_pVDE),
        .vid_pHSync    (vid_pHSync),
        .vid_pVSync    (vid_pVSync),
        .vid_pStb      (vid_pStb),
        .PixelClk      (PixelClk),
        .aPixelClkLckd (aPixelClkLckd),
        .pLocked       (pLocked),
        .SDA_I         (SDA_I),
        .SCL_I         (SCL_I),
        .SDA_O         (SDA_O),
        .SCL_O         (SCL_O),
        .SDA_T         (SDA_T),
        .SCL_T         (SCL_T)
    );

    assign TMDS_Clk_n  = ~TMDS_Clk_p;
    assign TMDS_Data_n = ~TMDS_Data_p;

    // Capture each strobed pixel and flag strobes wider than one cycle
    always @(negedge RefClk) begin
        if (vid_pStb) begin
            stb_seen  = stb_seen + 1;
            snap_data = vid_pData;
            snap_vde  = vid_pVDE;
        end
        if (vid_pStb && prev_stb) wide_stb = wide_stb + 1;
        prev_stb = vid_pStb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one word per lane, bit 0 first, clock lane high for bits 0..4
    task automatic send_word(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        for (int i = 0; i < 10; i++) begin
            TMDS_Clk_p  = (i < 5);
            TMDS_Data_p = {r[i], g[i], b[i]};
            @(negedge RefClk);
            if (i == 0) begin
                s_lck0  = aPixelClkLckd;
                s_plk0  = pLocked;
                s_pclk0 = PixelClk;
            end
            if (i == 5) s_pclk5 = PixelClk;
        end
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) begin
            TMDS_Clk_p  = 1'b0;
            TMDS_Data_p = 3'b000;
            @(negedge RefClk);
        end
    endtask

    // After send_word returns, snap_* holds the previous word's decode
    initial begin
        aRst        = 1'b1;
        TMDS_Clk_p  = 1'b0;
        TMDS_Data_p = 3'b000;
        SDA_I       = 1'b1;
        SCL_I       = 1'b1;
        repeat (5) @(negedge RefClk);

        check("rst_data",  32'(vid_pData), 32'h0);
        check("rst_vde",   32'(vid_pVDE), 32'h0);
        check("rst_hs",    32'(vid_pHSync), 32'h0);
        check("rst_vs",    32'(vid_pVSync), 32'h0);
        check("rst_stb",   32'(stb_seen), 32'h0);
        check("rst_pclk",  32'(PixelClk), 32'h0);
        check("rst_lck",   32'(aPixelClkLckd), 32'h0);
        check("rst_plk",   32'(pLocked), 32'h0);
        check("rst_ddc",   32'({SDA_O, SCL_O, SDA_T, SCL_T}), 32'h3);

        aRst = 1'b0;

        // Clock lane lock on the 4th aligned edge
        repeat (3) send_word(T354, T354, T354);
        check("lck_after3", 32'(aPixelClkLckd), 32'h0);
        send_word(T354, T354, T354);
        check("lck_after4", 32'(aPixelClkLckd), 32'h1);
        check("pclk_bit0",  32'(s_pclk0), 32'h1);
        check("pclk_bit5",  32'(s_pclk5), 32'h0);

        // Tokens count from word 3; the 8th (word 10) locks the link
        repeat (6) send_word(T354, T354, T354);
        send_word(T354, T354, T354);
        check("plk_before", 32'(pLocked), 32'h0);
        send_word(T354, T354, T354);
        check("plk_set",    32'(pLocked), 32'h1);
        check("sync_00",    32'({vid_pVSync, vid_pHSync}), 32'h0);
        check("ctrl_vde",   32'(snap_vde), 32'h0);

        // Blue control tokens drive the syncs
        send_word(T354, T354, T2AB);
        send_word(T354, T354, T354);
        check("sync_11",    32'({vid_pVSync, vid_pHSync}), 32'h3);
        check("c11_vde",    32'(snap_vde), 32'h0);
        check("c11_data",   32'(snap_data), 32'h0);
        send_word(T354, T354, T0AB);
        send_word(T354, T354, T154);
        check("sync_01",    32'({vid_pVSync, vid_pHSync}), 32'h1);
        send_word(D1FF, D1FF, D1FF);
        check("sync_10",    32'({vid_pVSync, vid_pHSync}), 32'h2);

        // Data period: one strobe per word, syncs hold
        stb_before = stb_seen;
        send_word(D1FF, D1FF, D1FF);
        check("d1ff_vde",   32'(snap_vde), 32'h1);
        check("d1ff_data",  32'(snap_data), 32'h010101);
        repeat (3) send_word(D1FF, D1FF, D1FF);
        check("stb_count",  32'(stb_seen - stb_before), 32'd4);
        check("stb_width",  32'(wide_stb), 32'd0);
        check("sync_hold",  32'({vid_pVSync, vid_pHSync}), 32'h2);

        send_word(D2F0, D155, D1FF);
        send_word(D1FF, T354, T2AB);
        check("mix_data_pix", 32'(snap_data), 32'hEFFF01);
        send_word(D1FF, D1FF, D1FF);
        check("mixed_vde",  32'(snap_vde), 32'h0);
        check("mixed_data", 32'(snap_data), 32'h0);
        check("mixed_sync", 32'({vid_pVSync, vid_pHSync}), 32'h3);
        check("plk_pre_shift", 32'(pLocked), 32'h1);

        // Clock edge 3 bits late: both locks drop on that edge
        send_idle(3);
        send_word(D1FF, D1FF, D1FF);
        check("shift_lck",  32'(s_lck0), 32'h0);
        check("shift_plk",  32'(s_plk0), 32'h0);
        send_word(T354, T354, T354);
        check("shift_vde",  32'(snap_vde), 32'h0);
        repeat (2) send_word(T354, T354, T354);
        check("relck_3",    32'(aPixelClkLckd), 32'h0);
        send_word(T354, T354, T354);
        check("relck_4",    32'(aPixelClkLckd), 32'h1);
        repeat (7) send_word(T354, T354, T354);
        check("replk_before", 32'(pLocked), 32'h0);
        send_word(T354, T354, T354);
        check("replk_set",  32'(pLocked), 32'h1);
        send_word(D2F0, D155, D1FF);
        send_word(D1FF, D1FF, D1FF);
        check("relock_pix", 32'(snap_data), 32'hEFFF01);
        check("relock_vde", 32'(vid_pVDE), 32'h1);

        // Asynchronous reset in the middle of a data period
        #1 aRst = 1'b1;
        #1;
        check("mrst_vde",   32'(vid_pVDE), 32'h0);
        check("mrst_data",  32'(vid_pData), 32'h0);
        check("mrst_locks", 32'({aPixelClkLckd, pLocked}), 32'h0);
        check("mrst_misc",  32'({vid_pStb, PixelClk, vid_pHSync, vid_pVSync}), 32'h0);
        repeat (3) @(negedge RefClk);
        aRst = 1'b0;

        // Data without tokens: clock locks, link does not
        repeat (6) send_word(D1FF, D1FF, D1FF);
        check("post_lck",   32'(aPixelClkLckd), 32'h1);
        check("post_plk",   32'(pLocked), 32'h0);
        check("post_vde",   32'(snap_vde), 32'h0);
        repeat (9) send_word(T354, T354, T354);
        check("post_plk_set", 32'(pLocked), 32'h1);
        send_word(D1FF, D1FF, D1FF);
        send_word(D1FF, D1FF, D1FF);
        check("post_pix",   32'(snap_data), 32'h010101);
        check("post_vde1",  32'(snap_vde), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
